// File: rtl/vend_ctrl_param_if.sv
// Coin-acceptor / dispenser handshake bundle for vend_ctrl_param.
// master = coin front end driving coins and cancel, slave = the controller.
interface vend_ctrl_param_if #(
  parameter int CREDIT_W = 6
);
  logic                coin5;
  logic                coin10;
  logic                coin20;
  logic                cancel;
  logic                dispense;
  logic                change_pulse;
  logic                coin_reject;
  logic                busy;
  logic [CREDIT_W-1:0] credit;

  modport master (
    output coin5, coin10, coin20, cancel,
    input  dispense, change_pulse, coin_reject, busy, credit
  );

  modport slave (
    input  coin5, coin10, coin20, cancel,
    output dispense, change_pulse, coin_reject, busy, credit
  );
endinterface

// File: rtl/vend_ctrl_param.sv
// Parametrised vending controller: collects 5/10/20 coins as 5-unit steps,
// dispenses at PRICE, then pays change or refunds one 5-unit coin per cycle.
module vend_ctrl_param #(
  parameter int CREDIT_W   = 6,
  parameter int PRICE      = 3,
  parameter int MAX_CREDIT = 10
) (
  input logic            clk,
  input logic            rst,
  vend_ctrl_param_if.slave bus
);
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_COLLECT  = 3'd1;
  localparam logic [2:0] S_DISPENSE = 3'd2;
  localparam logic [2:0] S_CHANGE   = 3'd3;
  localparam logic [2:0] S_REFUND   = 3'd4;

  // One extra bit so credit + coin never wraps before the overflow compare.
  localparam logic [CREDIT_W:0]   PRICE_W = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W:0]   MAX_W   = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] ONE     = CREDIT_W'(1);

  logic [2:0]          state, state_next;
  logic [CREDIT_W-1:0] credit_q, credit_next;
  logic                reject_q, reject_next;
  logic [1:0]          coin_count;
  logic [CREDIT_W:0]   coin_val, sum, remainder;
  logic                any_coin, accept;

  assign coin_count = {1'b0, bus.coin5} + {1'b0, bus.coin10} + {1'b0, bus.coin20};
  assign any_coin   = |coin_count;

  always_comb begin
    coin_val = '0;
    if (bus.coin5)       coin_val = (CREDIT_W+1)'(1);
    else if (bus.coin10) coin_val = (CREDIT_W+1)'(2);
    else if (bus.coin20) coin_val = (CREDIT_W+1)'(4);
  end

  assign sum       = {1'b0, credit_q} + coin_val;
  assign remainder = {1'b0, credit_q} - PRICE_W;
  assign accept    = (state == S_IDLE || state == S_COLLECT) && coin_count == 2'd1 &&
                     !bus.cancel && sum <= MAX_W;

  // Any coin that is not accepted, for whatever reason, goes back to the user.
  always_comb begin
    state_next  = state;
    credit_next = credit_q;
    reject_next = any_coin && !accept;
    case (state)
      S_IDLE, S_COLLECT: begin
        if (state == S_COLLECT && bus.cancel) begin
          state_next = S_REFUND;
        end else if (accept) begin
          credit_next = sum[CREDIT_W-1:0];
          state_next  = (sum >= PRICE_W) ? S_DISPENSE : S_COLLECT;
        end
      end
      S_DISPENSE: begin
        credit_next = remainder[CREDIT_W-1:0];
        state_next  = (remainder == '0) ? S_IDLE : S_CHANGE;
      end
      S_CHANGE, S_REFUND: begin
        if (credit_q <= ONE) begin
          credit_next = '0;
          state_next  = S_IDLE;
        end else begin
          credit_next = credit_q - ONE;
        end
      end
      default: begin
        credit_next = '0;
        state_next  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      credit_q <= '0;
      reject_q <= 1'b0;
    end else begin
      state    <= state_next;
      credit_q <= credit_next;
      reject_q <= reject_next;
    end
  end

  assign bus.dispense     = (state == S_DISPENSE);
  assign bus.change_pulse = (state == S_CHANGE) || (state == S_REFUND);
  assign bus.busy         = bus.dispense || bus.change_pulse;
  assign bus.coin_reject  = reject_q;
  assign bus.credit       = credit_q;
endmodule

// File: tb/tb_vend_ctrl_param.sv
// Scoreboard bench for vend_ctrl_param: a credit/payout-count model predicts
// output events, a negedge monitor compares whatever the DUT actually emits.
module tb_vend_ctrl_param;
  localparam int CREDIT_W   = 6;
  localparam int PRICE      = 3;
  localparam int MAX_CREDIT = 10;

  typedef struct packed {
    logic                disp;
    logic                chg;
    logic                rej;
    logic                busy;
    logic [CREDIT_W-1:0] credit;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vend_ctrl_param_if #(.CREDIT_W(CREDIT_W)) bus ();
  vend_ctrl_param_if #(.CREDIT_W(CREDIT_W)) bus_ov ();

  vend_ctrl_param #(.CREDIT_W(CREDIT_W), .PRICE(PRICE), .MAX_CREDIT(MAX_CREDIT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  vend_ctrl_param #(.CREDIT_W(CREDIT_W), .PRICE(3), .MAX_CREDIT(4)) dut_ov (
    .clk(clk), .rst(rst), .bus(bus_ov)
  );

  obs_t exp_q[$];
  int   checks = 0, failures = 0;
  int   disp_seen = 0, chg_seen = 0, rej_seen = 0, busy_seen = 0;
  int   m_credit = 0, m_prev_credit = 0;
  bit   m_disp = 1'b0, m_chg = 1'b0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Model: credit plus "dispense pending" and "still paying out" flags.
  task automatic model_step(input bit c5, input bit c10, input bit c20, input bit cn);
    int   n, val;
    bit   accepted;
    obs_t o;
    n        = int'(c5) + int'(c10) + int'(c20);
    val      = c5 ? 1 : (c10 ? 2 : (c20 ? 4 : 0));
    accepted = 1'b0;
    if (m_disp) begin
      m_credit -= PRICE;
      m_disp    = 1'b0;
      m_chg     = (m_credit > 0);
    end else if (m_chg) begin
      m_credit -= 1;
      m_chg     = (m_credit > 0);
    end else if (cn && m_credit > 0) begin
      m_chg = 1'b1;
    end else if (n == 1 && !cn && m_credit + val <= MAX_CREDIT) begin
      accepted  = 1'b1;
      m_credit += val;
      m_disp    = (m_credit >= PRICE);
    end
    o.disp   = m_disp;
    o.chg    = m_chg;
    o.rej    = (n > 0) && !accepted;
    o.busy   = m_disp || m_chg;
    o.credit = CREDIT_W'(m_credit);
    if (o.disp || o.chg || o.rej || m_credit != m_prev_credit) exp_q.push_back(o);
    m_prev_credit = m_credit;
  endtask

  task automatic model_reset();
    m_credit      = 0;
    m_prev_credit = 0;
    m_disp        = 1'b0;
    m_chg         = 1'b0;
    exp_q.delete();
  endtask

  task automatic apply_stimulus(input bit c5, input bit c10, input bit c20, input bit cn);
    @(negedge clk);
    #1;
    bus.coin5  = c5;
    bus.coin10 = c10;
    bus.coin20 = c20;
    bus.cancel = cn;
    model_step(c5, c10, c20, cn);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic apply_ov(input bit c5, input bit c10, input bit c20);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    bus_ov.coin5  = c5;
    bus_ov.coin10 = c10;
    bus_ov.coin20 = c20;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [CREDIT_W-1:0] prev;
    obs_t                e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev = bus.credit;
      end else begin
        if (bus.busy) busy_seen++;
        if (bus.dispense || bus.change_pulse || bus.coin_reject || bus.credit != prev) begin
          if (bus.dispense)     disp_seen++;
          if (bus.change_pulse) chg_seen++;
          if (bus.coin_reject)  rej_seen++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL sb_unexpected: got disp=%0b chg=%0b rej=%0b credit=%0d expected no event",
                     bus.dispense, bus.change_pulse, bus.coin_reject, bus.credit);
          end else begin
            e = exp_q.pop_front();
            check_output("sb_dispense", bus.dispense, e.disp);
            check_output("sb_change", bus.change_pulse, e.chg);
            check_output("sb_reject", bus.coin_reject, e.rej);
            check_output("sb_busy", bus.busy, e.busy);
            check_output("sb_credit", bus.credit, e.credit);
          end
        end
        prev = bus.credit;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0, c0, r0, b0, r;
    {bus.coin5, bus.coin10, bus.coin20, bus.cancel} = 4'b0;
    {bus_ov.coin5, bus_ov.coin10, bus_ov.coin20, bus_ov.cancel} = 4'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_credit", bus.credit, 0);
    check_output("rst_dispense", bus.dispense, 0);
    check_output("rst_change", bus.change_pulse, 0);
    check_output("rst_reject", bus.coin_reject, 0);
    check_output("rst_busy", bus.busy, 0);
    @(negedge clk);
    #1;
    rst = 1'b1;

    // Exact price: 5 then 10.
    d0 = disp_seen; c0 = chg_seen;
    apply_stimulus(1, 0, 0, 0); after_edge();
    check_output("exact_credit1", bus.credit, 1);
    apply_stimulus(0, 1, 0, 0); after_edge();
    check_output("exact_credit3", bus.credit, 3);
    check_output("exact_dispense", bus.dispense, 1);
    apply_stimulus(0, 0, 0, 0); after_edge();
    check_output("exact_credit0", bus.credit, 0);
    check_output("exact_idle", bus.busy, 0);
    idle(2);
    check_output("exact_disp_count", disp_seen - d0, 1);
    check_output("exact_chg_count", chg_seen - c0, 0);

    // Change: 5 then 20 leaves two coins of change.
    d0 = disp_seen; c0 = chg_seen;
    apply_stimulus(1, 0, 0, 0);
    apply_stimulus(0, 0, 1, 0); after_edge();
    check_output("change_credit5", bus.credit, 5);
    idle(5);
    check_output("change_disp_count", disp_seen - d0, 1);
    check_output("change_chg_count", chg_seen - c0, 2);
    check_output("change_credit_end", bus.credit, 0);

    // Cancel refunds credit without dispensing.
    d0 = disp_seen; c0 = chg_seen; b0 = busy_seen;
    apply_stimulus(0, 1, 0, 0);
    apply_stimulus(0, 0, 0, 1);
    idle(4);
    check_output("cancel_chg_count", chg_seen - c0, 2);
    check_output("cancel_disp_count", disp_seen - d0, 0);
    check_output("cancel_busy_cycles", busy_seen - b0, 2);

    // Cancel while idle does nothing.
    d0 = disp_seen; c0 = chg_seen; r0 = rej_seen; b0 = busy_seen;
    apply_stimulus(0, 0, 0, 1);
    idle(3);
    check_output("idle_cancel_activity", (disp_seen - d0) + (chg_seen - c0) + (rej_seen - r0), 0);
    check_output("idle_cancel_busy", busy_seen - b0, 0);

    // Two coins at once.
    r0 = rej_seen;
    apply_stimulus(1, 1, 0, 0); after_edge();
    check_output("dual_reject", bus.coin_reject, 1);
    check_output("dual_credit", bus.credit, 0);
    idle(2);
    check_output("dual_reject_count", rej_seen - r0, 1);

    // Coin during payout is rejected and does not alter the change count.
    c0 = chg_seen; r0 = rej_seen;
    apply_stimulus(1, 0, 0, 0);
    apply_stimulus(0, 0, 1, 0);
    apply_stimulus(0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0);
    idle(4);
    check_output("busy_coin_chg_count", chg_seen - c0, 2);
    check_output("busy_coin_reject_count", rej_seen - r0, 1);

    // Overflow with PRICE=3, MAX_CREDIT=4.
    apply_ov(0, 1, 0); after_edge();
    check_output("ov_credit2", bus_ov.credit, 2);
    apply_ov(0, 0, 1); after_edge();
    check_output("ov_reject", bus_ov.coin_reject, 1);
    check_output("ov_credit_hold", bus_ov.credit, 2);
    apply_ov(1, 0, 0); after_edge();
    check_output("ov_dispense", bus_ov.dispense, 1);
    apply_ov(0, 0, 0); after_edge();
    check_output("ov_no_change", bus_ov.change_pulse, 0);
    check_output("ov_credit_end", bus_ov.credit, 0);
    check_output("ov_busy_end", bus_ov.busy, 0);

    // Reset during the first change cycle.
    apply_stimulus(0, 0, 1, 0);
    apply_stimulus(0, 0, 0, 0); after_edge();
    check_output("rstpay_change_before", bus.change_pulse, 1);
    rst = 1'b0;
    #1;
    model_reset();
    check_output("rstpay_dispense", bus.dispense, 0);
    check_output("rstpay_change", bus.change_pulse, 0);
    check_output("rstpay_reject", bus.coin_reject, 0);
    check_output("rstpay_busy", bus.busy, 0);
    check_output("rstpay_credit", bus.credit, 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    idle(2);
    check_output("rstpay_idle_busy", bus.busy, 0);
    apply_stimulus(1, 0, 0, 0); after_edge();
    check_output("rstpay_accept", bus.credit, 1);
    idle(2);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 15)      apply_stimulus(1, 0, 0, 0);
      else if (r < 27) apply_stimulus(0, 1, 0, 0);
      else if (r < 37) apply_stimulus(0, 0, 1, 0);
      else if (r < 41) apply_stimulus(1'($urandom), 1, 1'($urandom), 0);
      else if (r < 46) apply_stimulus(0, 0, 0, 1);
      else if (r < 48) apply_stimulus(1, 0, 0, 1);
      else             apply_stimulus(0, 0, 0, 0);
    end
    idle(15);
    @(negedge clk);
    #2;
    check_output("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vend_ctrl_param.md
# vend_ctrl_param

Parametrised coin-operated vending controller, the next generation of the lab's fixed-price water vending FSM. It accepts three coin denominations (5, 10, 20) and accumulates credit in 5-unit steps up to a configurable price. It then dispenses one item and pays out change one 5-unit coin per cycle. It adds cancel/refund, over-credit and invalid-coin rejection, and a visible credit count, and sits between the coin-acceptor front end and the dispenser/coin-hopper drivers.

## Interface
- CREDIT_W, 6, width of the credit register; credit is counted in 5-unit steps.
- PRICE, 3, item price in 5-unit steps (default 15). Must satisfy 1 ≤ PRICE ≤ MAX_CREDIT.
- MAX_CREDIT, 10, maximum credit in 5-unit steps that may be held after a coin is added. Must satisfy MAX_CREDIT < 2**CREDIT_W.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- coin5  in  1  one-cycle pulse; a 5-unit coin was inserted.
- coin10  in  1  one-cycle pulse; a 10-unit coin was inserted.
- coin20  in  1  one-cycle pulse; a 20-unit coin was inserted.
- cancel  in  1  one-cycle pulse; refund the accumulated credit.
- dispense  out  1  high for exactly one cycle per item.
- change_pulse  out  1  high for one cycle per 5-unit coin returned.
- coin_reject  out  1  registered; high for one cycle when a coin was not accepted (coin must be returned mechanically).
- busy  out  1  high in DISPENSE, CHANGE and REFUND.
- credit  out  CREDIT_W  current credit in 5-unit steps.

## Operation
- States: IDLE (credit = 0), COLLECT (0 < credit < PRICE), DISPENSE, CHANGE, REFUND.
- Coin value in steps: coin5 = 1, coin10 = 2, coin20 = 4.
- Coin acceptance happens only in IDLE or COLLECT, when exactly one coin input is high and cancel is low.
  - If credit + value ≤ MAX_CREDIT: credit += value.
  - If the new credit ≥ PRICE: go to DISPENSE.
  - Otherwise: go to COLLECT.
- Coin rejection sets coin_reject for the next cycle and leaves credit and state unchanged. A coin is rejected when:
  - two or more coin inputs are high in the same cycle;
  - credit + value > MAX_CREDIT;
  - any coin input is high while busy;
  - a coin arrives in the same cycle as an accepted cancel.
- DISPENSE: dispense = 1 for one cycle; credit -= PRICE.
  - Next state is CHANGE if the remainder is > 0, otherwise IDLE.
- CHANGE and REFUND:
  - change_pulse = 1 in every cycle of the state; credit decrements by 1 at each edge.
  - The state exits to IDLE on the edge where credit reaches 0.
  - REFUND never asserts dispense.
- cancel is acted on only in COLLECT, where it moves the block to REFUND. cancel is ignored in IDLE and while busy.
- Outputs dispense, change_pulse and busy are decoded from the state register only (Moore). credit is driven directly from its register.
- Width rules:
  - Credit arithmetic is done CREDIT_W+1 bits wide, so the overflow comparison cannot wrap.
  - Credit never exceeds MAX_CREDIT and never goes below 0.
- Illegal state encodings go to IDLE with credit cleared.

## Timing
- Reset (asynchronous, at any time including mid-payout):
  - state goes to IDLE and credit to 0;
  - dispense, change_pulse, coin_reject and busy all go to 0;
  - any pending change is lost.
- A coin is sampled at edge N. After edge N, credit shows the new value and coin_reject (if any) is high for the cycle N to N+1.
- The price is reached at edge N:
  - dispense is high for the cycle N to N+1;
  - the first change_pulse occurs in the cycle N+1 to N+2;
  - k change steps take exactly k consecutive cycles;
  - IDLE is reached at edge N+1+k.
- Cancel at edge N with credit c: change_pulse is high for cycles N+1 … N+c (c cycles), then the block is in IDLE.
- A coin may be accepted on the very first edge after the block returns to IDLE. There is no dead cycle.

## Test plan
- Exact price, defaults: coin5 then coin10 on consecutive edges.
  - Required: credit reads 1 then 3; one dispense cycle; no change_pulse; credit 0 and IDLE the next cycle.
- Change, defaults: coin5 then coin20, giving credit 5.
  - Required: one dispense cycle, then exactly 2 change_pulse cycles, then IDLE with credit 0.
- Cancel: coin10, then cancel.
  - Required: 2 change_pulse cycles; dispense never asserted; busy high for 2 cycles.
  - Also: cancel in IDLE produces no output activity.
- Rejection, defaults:
  - coin5 and coin10 in the same cycle → coin_reject for 1 cycle, credit stays 0.
  - coin5 during CHANGE → coin_reject, payout count unchanged.
- Overflow, PRICE=3 and MAX_CREDIT=4:
  - credit 2 then coin20 → coin_reject, credit stays 2;
  - a following coin5 → dispense, 0 change.
- Reset mid-payout: coin20 with defaults, then assert rst during the first change_pulse cycle.
  - Required: all outputs 0 immediately; credit 0; IDLE after rst is released.
